// File: rtl/trans_fifo_in_ep_ctrl_if.sv
// TX stream, handshake and FIFO pop-side signals of one USB IN endpoint controller.
// Signal suffixes are from the controller's side: master = controller, slave = engine/serializer/FIFO.
interface trans_fifo_in_ep_ctrl_if #(
    parameter int DATA_WID = 8
);
    logic                txReq_i;
    logic                hsValid_i;
    logic                hsAck_i;
    logic                txValid_o;
    logic                txReady_i;
    logic [DATA_WID-1:0] txData_o;
    logic                txLast_o;
    logic                txEmpty_o;
    logic                txDone_o;
    logic                txOk_o;
    logic                fifoPopData_o;
    logic                fifoPopTransDone_o;
    logic                fifoPopTransSuccess_o;
    logic                fifoDataAvailable_i;
    logic                fifoIsLast_i;
    logic [DATA_WID-1:0] fifoData_i;
`ifdef IN_EP_RETRY_LIMIT_EN
    logic                txDropped_o;
`endif

    // TX stream: a beat transfers on a cycle where txValid_o & txReady_i; txValid_o never waits on txReady_i.
    modport master (
        input  txReq_i, hsValid_i, hsAck_i, txReady_i,
        input  fifoDataAvailable_i, fifoIsLast_i, fifoData_i,
        output txValid_o, txData_o, txLast_o, txEmpty_o, txDone_o, txOk_o,
`ifdef IN_EP_RETRY_LIMIT_EN
        output txDropped_o,
`endif
        output fifoPopData_o, fifoPopTransDone_o, fifoPopTransSuccess_o
    );

    modport slave (
        output txReq_i, hsValid_i, hsAck_i, txReady_i,
        output fifoDataAvailable_i, fifoIsLast_i, fifoData_i,
        input  txValid_o, txData_o, txLast_o, txEmpty_o, txDone_o, txOk_o,
`ifdef IN_EP_RETRY_LIMIT_EN
        input  txDropped_o,
`endif
        input  fifoPopData_o, fifoPopTransDone_o, fifoPopTransSuccess_o
    );
endinterface

// File: rtl/trans_fifo_in_ep_ctrl.sv
// Pop-side sequencer of a transactional FIFO for one USB IN endpoint: send, await handshake, commit or roll back.
// Optional IN_EP_RETRY_LIMIT_EN: drop (commit) the packet after MAX_RETRIES consecutive failures.
module trans_fifo_in_ep_ctrl #(
    parameter int DATA_WID    = 8,
    parameter int MAX_PKT_LEN = 64,
    parameter int LEN_WID     = 7,
    parameter int HS_TIMEOUT  = 32,
    parameter int MAX_RETRIES = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    trans_fifo_in_ep_ctrl_if.master bus,
    output logic [2:0]              state_o
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND     = 3'd1;
    localparam logic [2:0] WAIT_HS  = 3'd2;
    localparam logic [2:0] COMMIT   = 3'd3;
    localparam logic [2:0] ROLLBACK = 3'd4;

    localparam int RETRY_WID = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int TMR_WID   = $clog2(HS_TIMEOUT);

    localparam logic [LEN_WID-1:0]   LAST_CNT  = LEN_WID'(MAX_PKT_LEN - 1);
    localparam logic [TMR_WID-1:0]   TMR_LAST  = TMR_WID'(HS_TIMEOUT - 1);
    localparam logic [RETRY_WID-1:0] RETRY_SAT = '1;

    logic [2:0]           state_q, state_d;
    logic [LEN_WID-1:0]   cnt_q, cnt_d;
    logic [TMR_WID-1:0]   tmr_q, tmr_d;
    logic [RETRY_WID-1:0] retry_q, retry_d;
    logic                 zlp_q, zlp_d;
    logic                 hs_fail;
    logic                 valid_c, last_c, empty_c, pop_c;
    logic                 done_c, ok_c, tdone_c, succ_c;
`ifdef IN_EP_RETRY_LIMIT_EN
    localparam logic [RETRY_WID-1:0] RETRY_LIMIT = RETRY_WID'(MAX_RETRIES - 1);
    logic                 drop_q, drop_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        retry_d = retry_q;
        zlp_d   = zlp_q;
        hs_fail = 1'b0;
        valid_c = 1'b0;
        last_c  = 1'b0;
        empty_c = 1'b0;
        pop_c   = 1'b0;
        done_c  = 1'b0;
        ok_c    = 1'b0;
        tdone_c = 1'b0;
        succ_c  = 1'b0;
`ifdef IN_EP_RETRY_LIMIT_EN
        drop_d  = drop_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.txReq_i) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    zlp_d   = !bus.fifoDataAvailable_i;
                end
            end
            SEND: begin
                if (zlp_q) begin
                    valid_c = 1'b1;
                    last_c  = 1'b1;
                    empty_c = 1'b1;
                    if (bus.txReady_i) begin
                        state_d = WAIT_HS;
                        tmr_d   = '0;
                    end
                end else begin
                    // Packet length cap forces txLast even when more data remains.
                    valid_c = bus.fifoDataAvailable_i;
                    last_c  = bus.fifoIsLast_i | (cnt_q == LAST_CNT);
                    pop_c   = valid_c & bus.txReady_i;
                    if (pop_c) begin
                        cnt_d = cnt_q + LEN_WID'(1);
                        if (last_c) begin
                            state_d = WAIT_HS;
                            tmr_d   = '0;
                        end
                    end
                end
            end
            WAIT_HS: begin
                tmr_d = tmr_q + TMR_WID'(1);
                if (bus.hsValid_i) begin
                    if (bus.hsAck_i) state_d = COMMIT;
                    else             hs_fail = 1'b1;
                end else if (tmr_q == TMR_LAST) begin
                    hs_fail = 1'b1;
                end
                if (hs_fail) begin
`ifdef IN_EP_RETRY_LIMIT_EN
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = COMMIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = ROLLBACK;
                    end
`else
                    state_d = ROLLBACK;
`endif
                end
            end
            COMMIT: begin
                tdone_c = 1'b1;
                succ_c  = 1'b1;
                done_c  = 1'b1;
`ifdef IN_EP_RETRY_LIMIT_EN
                ok_c    = !drop_q;
                drop_d  = 1'b0;
`else
                ok_c    = 1'b1;
`endif
                retry_d = '0;
                state_d = IDLE;
            end
            ROLLBACK: begin
                tdone_c = 1'b1;
                done_c  = 1'b1;
                if (retry_q != RETRY_SAT) retry_d = retry_q + RETRY_WID'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            retry_q <= '0;
            zlp_q   <= 1'b0;
`ifdef IN_EP_RETRY_LIMIT_EN
            drop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            retry_q <= retry_d;
            zlp_q   <= zlp_d;
`ifdef IN_EP_RETRY_LIMIT_EN
            drop_q  <= drop_d;
`endif
        end
    end

    assign bus.txValid_o             = valid_c;
    assign bus.txLast_o              = last_c;
    assign bus.txEmpty_o             = empty_c;
    assign bus.txData_o              = (state_q == SEND && !zlp_q) ? bus.fifoData_i : {DATA_WID{1'b0}};
    assign bus.txDone_o              = done_c;
    assign bus.txOk_o                = ok_c;
    assign bus.fifoPopData_o         = pop_c;
    assign bus.fifoPopTransDone_o    = tdone_c;
    assign bus.fifoPopTransSuccess_o = succ_c;
`ifdef IN_EP_RETRY_LIMIT_EN
    assign bus.txDropped_o           = (state_q == COMMIT) & drop_q;
`endif
    assign state_o                   = state_q;
endmodule

// File: tb/tb_trans_fifo_in_ep_ctrl.sv
// Directed bench for trans_fifo_in_ep_ctrl with a transactional FIFO model and a byte scoreboard.
module tb_trans_fifo_in_ep_ctrl;
    localparam int HS_TIMEOUT = 32;
    localparam logic [2:0] S_IDLE = 3'd0, S_SEND = 3'd1, S_WAIT = 3'd2, S_COMMIT = 3'd3, S_ROLLBACK = 3'd4;
    // Output vector {valid,last,empty,done,ok,pop,tdone,succ}
    localparam logic [7:0] O_IDLE = 8'h00, O_COMMIT = 8'h1B, O_ROLLBACK = 8'h12, O_ZLP = 8'hE0;

    logic       clk, rst;
    logic [2:0] state;
    int         errors, checks;

    trans_fifo_in_ep_ctrl_if #(.DATA_WID(8)) bus ();

    trans_fifo_in_ep_ctrl #(
        .DATA_WID(8), .MAX_PKT_LEN(64), .LEN_WID(7), .HS_TIMEOUT(HS_TIMEOUT), .MAX_RETRIES(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .state_o(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transactional FIFO model: speculative read pointer, committed read pointer.
    logic [7:0] mem [0:255];
    int wr_ptr, rd_ptr, rd_commit;
    assign bus.fifoDataAvailable_i = (rd_ptr < wr_ptr);
    assign bus.fifoIsLast_i        = (rd_ptr == wr_ptr - 1);
    assign bus.fifoData_i          = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= 0;
            rd_commit <= 0;
        end else begin
            if (bus.fifoPopData_o) rd_ptr <= rd_ptr + 1;
            if (bus.fifoPopTransDone_o) begin
                if (bus.fifoPopTransSuccess_o) rd_commit <= rd_ptr;
                else                           rd_ptr    <= rd_commit;
            end
        end
    end

    // Monitor: accepted beats and pulse counts.
    logic [7:0] got_q[$];
    logic       last_q[$];
    logic [7:0] exp_q[$];
    int pop_cnt = 0, empty_cnt = 0, tdone_cnt = 0, overlap_cnt = 0;

    always @(posedge clk) begin
        if (bus.txValid_o && bus.txReady_i) begin
            if (bus.txEmpty_o) empty_cnt <= empty_cnt + 1;
            else begin
                got_q.push_back(bus.txData_o);
                last_q.push_back(bus.txLast_o);
            end
        end
        if (bus.fifoPopData_o)      pop_cnt   <= pop_cnt + 1;
        if (bus.fifoPopTransDone_o) tdone_cnt <= tdone_cnt + 1;
        if (bus.fifoPopData_o && bus.fifoPopTransDone_o) overlap_cnt <= overlap_cnt + 1;
    end

    function automatic logic [7:0] outs();
        return {bus.txValid_o, bus.txLast_o, bus.txEmpty_o, bus.txDone_o, bus.txOk_o,
                bus.fifoPopData_o, bus.fifoPopTransDone_o, bus.fifoPopTransSuccess_o};
    endfunction

    task automatic fifo_push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic send_req();
        @(negedge clk); bus.txReq_i = 1'b1;
        @(negedge clk); bus.txReq_i = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == st) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_hs(input logic ack);
        bus.hsValid_i = 1'b1; bus.hsAck_i = ack;
        @(negedge clk);
        bus.hsValid_i = 1'b0; bus.hsAck_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        checks++; if (outs() !== O_IDLE) begin errors++; $display("FAIL reset_outs: got %02h expected %02h", outs(), O_IDLE); end
        checks++; if (bus.txData_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", bus.txData_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_commit();
        int base, pops0; bit ok;
        exp_q = '{8'h11, 8'h22, 8'h33};
        foreach (exp_q[i]) fifo_push(exp_q[i]);
        base = got_q.size(); pops0 = pop_cnt;
        bus.txReady_i = 1'b1;
        send_req();
        wait_state(S_WAIT, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL commit_wait_hs: timed out, state %0d", state); end
        checks++; if (got_q.size() - base !== 3) begin errors++; $display("FAIL commit_beats: got %0d expected 3", got_q.size() - base); end
        for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL commit_byte%0d: got %02h expected %02h", i, got_q[base+i], exp_q[i]); end
            checks++; if (last_q[base+i] !== (i == 2)) begin errors++; $display("FAIL commit_last%0d: got %0b expected %0b", i, last_q[base+i], i == 2); end
        end
        checks++; if (pop_cnt - pops0 !== 3) begin errors++; $display("FAIL commit_pops: got %0d expected 3", pop_cnt - pops0); end
        do_hs(1'b1);
        checks++; if (outs() !== O_COMMIT) begin errors++; $display("FAIL commit_outs: got %02h expected %02h", outs(), O_COMMIT); end
        @(negedge clk);
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL commit_idle: got %0d expected %0d", state, S_IDLE); end
        checks++; if (bus.fifoDataAvailable_i !== 1'b0) begin errors++; $display("FAIL commit_fifo_empty: got %0b expected 0", bus.fifoDataAvailable_i); end
    endtask

    task automatic test_rollback();
        int base; bit ok;
        exp_q = '{8'h11, 8'h22, 8'h33};
        foreach (exp_q[i]) fifo_push(exp_q[i]);
        send_req();
        wait_state(S_WAIT, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rb_wait_hs: timed out, state %0d", state); end
        do_hs(1'b0);
        checks++; if (outs() !== O_ROLLBACK) begin errors++; $display("FAIL rb_outs: got %02h expected %02h", outs(), O_ROLLBACK); end
        @(negedge clk);
        base = got_q.size();
        send_req();
        wait_state(S_WAIT, 20, ok);
        checks++; if (got_q.size() - base !== 3) begin errors++; $display("FAIL rb_resend_beats: got %0d expected 3", got_q.size() - base); end
        for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL rb_resend_byte%0d: got %02h expected %02h", i, got_q[base+i], exp_q[i]); end
        end
        do_hs(1'b1);
        checks++; if (outs() !== O_COMMIT) begin errors++; $display("FAIL rb_commit_outs: got %02h expected %02h", outs(), O_COMMIT); end
        @(negedge clk);
    endtask

    task automatic test_max_len();
        int base; bit ok;
        exp_q.delete();
        for (int i = 0; i < 70; i++) begin
            exp_q.push_back(8'(i + 1));
            fifo_push(8'(i + 1));
        end
        base = got_q.size();
        send_req();
        wait_state(S_WAIT, 200, ok);
        checks++; if (got_q.size() - base !== 64) begin errors++; $display("FAIL max_beats: got %0d expected 64", got_q.size() - base); end
        for (int i = 0; i < 64 && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_q[i] || last_q[base+i] !== (i == 63)) begin
                errors++; $display("FAIL max_beat%0d: got %02h/last=%0b expected %02h/last=%0b", i, got_q[base+i], last_q[base+i], exp_q[i], i == 63);
            end
        end
        do_hs(1'b1);
        @(negedge clk);
        base = got_q.size();
        send_req();
        wait_state(S_WAIT, 40, ok);
        checks++; if (got_q.size() - base !== 6) begin errors++; $display("FAIL tail_beats: got %0d expected 6", got_q.size() - base); end
        for (int i = 0; i < 6 && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_q[64+i] || last_q[base+i] !== (i == 5)) begin
                errors++; $display("FAIL tail_beat%0d: got %02h/last=%0b expected %02h/last=%0b", i, got_q[base+i], last_q[base+i], exp_q[64+i], i == 5);
            end
        end
        do_hs(1'b1);
        @(negedge clk);
    endtask

    task automatic test_zlp();
        int pops0, empty0; bit ok;
        pops0 = pop_cnt; empty0 = empty_cnt;
        send_req();
        checks++; if (state !== S_SEND || outs() !== O_ZLP) begin errors++; $display("FAIL zlp_beat: got state %0d outs %02h expected %0d %02h", state, outs(), S_SEND, O_ZLP); end
        wait_state(S_WAIT, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zlp_wait_hs: timed out, state %0d", state); end
        checks++; if (empty_cnt - empty0 !== 1) begin errors++; $display("FAIL zlp_count: got %0d expected 1", empty_cnt - empty0); end
        checks++; if (pop_cnt - pops0 !== 0) begin errors++; $display("FAIL zlp_pops: got %0d expected 0", pop_cnt - pops0); end
        do_hs(1'b1);
        checks++; if (outs() !== O_COMMIT) begin errors++; $display("FAIL zlp_commit: got %02h expected %02h", outs(), O_COMMIT); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int base; bit ok, stay;
        fifo_push(8'h5A);
        send_req();
        wait_state(S_WAIT, 10, ok);
        stay = ok;
        for (int k = 1; k < HS_TIMEOUT; k++) begin
            @(negedge clk);
            if (state !== S_WAIT) stay = 1'b0;
        end
        checks++; if (!stay) begin errors++; $display("FAIL to_hold: left WAIT_HS early, state %0d", state); end
        @(negedge clk);
        checks++; if (state !== S_ROLLBACK || outs() !== O_ROLLBACK) begin errors++; $display("FAIL to_rollback: got state %0d outs %02h expected %0d %02h", state, outs(), S_ROLLBACK, O_ROLLBACK); end
        @(negedge clk);
        base = got_q.size();
        send_req();
        wait_state(S_WAIT, 10, ok);
        checks++; if (got_q.size() - base !== 1 || got_q[got_q.size()-1] !== 8'h5A) begin errors++; $display("FAIL to_resend: got %0d beats last %02h expected 1 beat 5a", got_q.size() - base, got_q[got_q.size()-1]); end
        repeat (HS_TIMEOUT - 1) @(negedge clk);
        do_hs(1'b1);
        checks++; if (state !== S_COMMIT || outs() !== O_COMMIT) begin errors++; $display("FAIL to_hs_precedence: got state %0d outs %02h expected %0d %02h", state, outs(), S_COMMIT, O_COMMIT); end
        @(negedge clk);
    endtask

    task automatic test_stall_reset();
        int base, pops0, td0; bit ok;
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        foreach (exp_q[i]) fifo_push(exp_q[i]);
        base = got_q.size(); pops0 = pop_cnt;
        send_req();
        @(negedge clk); bus.txReady_i = 1'b0;
        repeat (2) @(negedge clk);
        bus.txReady_i = 1'b1;
        wait_state(S_WAIT, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_wait_hs: timed out, state %0d", state); end
        checks++; if (got_q.size() - base !== 4) begin errors++; $display("FAIL stall_beats: got %0d expected 4", got_q.size() - base); end
        for (int i = 0; i < 4 && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d: got %02h expected %02h", i, got_q[base+i], exp_q[i]); end
        end
        checks++; if (pop_cnt - pops0 !== 4) begin errors++; $display("FAIL stall_pops: got %0d expected 4", pop_cnt - pops0); end
        td0 = tdone_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr_ptr = 0;
        checks++; if (state !== S_IDLE || outs() !== O_IDLE) begin errors++; $display("FAIL rst_mid: got state %0d outs %02h expected %0d %02h", state, outs(), S_IDLE, O_IDLE); end
        repeat (2) @(negedge clk);
        checks++; if (tdone_cnt !== td0) begin errors++; $display("FAIL rst_no_transdone: got %0d pulses expected 0", tdone_cnt - td0); end
    endtask

    task automatic test_exclusive();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL pop_transdone_overlap: got %0d expected 0", overlap_cnt); end
    endtask

    initial begin
        errors = 0; checks = 0; wr_ptr = 0;
        rst = 1'b1;
        bus.txReq_i = 1'b0; bus.hsValid_i = 1'b0; bus.hsAck_i = 1'b0; bus.txReady_i = 1'b0;
        test_reset();
        test_commit();
        test_rollback();
        test_max_len();
        test_zlp();
        test_timeout();
        test_stall_reset();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trans_fifo_in_ep_ctrl.md
Name: trans_fifo_in_ep_ctrl

Overview:
- Sequences the pop side of the transactional BRAM FIFO for one USB IN endpoint.
- On a packet request from the protocol engine it streams up to MAX_PKT_LEN bytes to the TX serializer, then waits for the host handshake.
- On ACK it commits the pop transaction. On failure or timeout it rolls the transaction back so the same bytes are resent on the next request.

Parameters:
- DATA_WID, 8, byte width of FIFO and TX stream.
- MAX_PKT_LEN, 64, maximum payload bytes per packet (wMaxPacketSize).
- LEN_WID, 7, width of the packet byte counter; must satisfy 2**LEN_WID > MAX_PKT_LEN.
- HS_TIMEOUT, 32, cycles to wait in WAIT_HS before declaring failure (>=2).
- MAX_RETRIES, 3, consecutive failures before drop; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- txReq_i  in  1  1-cycle pulse: IN token accepted, send a data packet.
- hsValid_i  in  1  1-cycle pulse: handshake result available.
- hsAck_i  in  1  qualified by hsValid_i; 1 = ACK, 0 = failure/NAK.
- txValid_o  out  1  TX byte valid.
- txReady_i  in  1  serializer accepts the byte.
- txData_o  out  DATA_WID  TX byte; equals fifoData_i.
- txLast_o  out  1  current beat is the last of the packet.
- txEmpty_o  out  1  zero-length packet beat; txData_o is don't-care.
- txDone_o  out  1  1-cycle pulse: packet sequence finished.
- txOk_o  out  1  qualified by txDone_o; 1 = committed, 0 = rolled back.
- fifoPopData_o  out  1  to FIFO popData_i.
- fifoPopTransDone_o  out  1  to FIFO popTransDone_i.
- fifoPopTransSuccess_o  out  1  to FIFO popTransSuccess_i.
- fifoDataAvailable_i  in  1  from FIFO dataAvailable_o.
- fifoIsLast_i  in  1  from FIFO isLast_o.
- fifoData_i  in  DATA_WID  from FIFO data_o.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, byte counter 0, retry counter 0, zlp flag 0, timeout counter 0.
- Reset mid-packet: the block returns to IDLE with no TransDone pulse. The FIFO shares rst_i.
- States: IDLE, SEND, WAIT_HS, COMMIT, ROLLBACK.
- IDLE:
  - On txReq_i go to SEND and clear the byte counter.
  - Latch zlp = !fifoDataAvailable_i in the same cycle.
  - hsValid_i is ignored in IDLE.
- SEND, normal packet:
  - txValid_o = fifoDataAvailable_i.
  - fifoPopData_o = txValid_o & txReady_i, combinational, zero latency.
  - txLast_o = fifoIsLast_i | (count == MAX_PKT_LEN-1).
  - Each accepted beat increments the counter (LEN_WID bits, no wrap possible).
  - The accepted beat with txLast_o=1 moves to WAIT_HS.
  - txValid_o low is a stall and does not end the packet.
- SEND, zlp=1:
  - Present exactly one beat: txValid_o=1, txLast_o=1, txEmpty_o=1, fifoPopData_o=0.
  - When the beat is accepted, go to WAIT_HS.
- txReq_i outside IDLE is ignored; no queuing.
- WAIT_HS:
  - Timer counts up from 0 on entry.
  - hsValid_i & hsAck_i goes to COMMIT.
  - hsValid_i & !hsAck_i goes to ROLLBACK.
  - Timer reaching HS_TIMEOUT-1 without hsValid_i goes to ROLLBACK.
  - If hsValid_i arrives in the timeout cycle, hsValid_i takes precedence.
- COMMIT (1 cycle):
  - fifoPopTransDone_o=1, fifoPopTransSuccess_o=1, txDone_o=1, txOk_o=1.
  - Retry counter cleared; next state IDLE.
- ROLLBACK (1 cycle):
  - fifoPopTransDone_o=1, fifoPopTransSuccess_o=0, txDone_o=1, txOk_o=0.
  - Retry counter incremented; next state IDLE.
- fifoPopData_o and fifoPopTransDone_o are never asserted in the same cycle; this is guaranteed by state separation.
- A ZLP still commits or rolls back; with no bytes popped this is a no-op for the FIFO.
- Exactly MAX_PKT_LEN bytes with more data remaining: txLast_o is forced on the last beat, and the remaining bytes go out on the next request.

Optional Feature:
- Macro: IN_EP_RETRY_LIMIT_EN.
- Enabled:
  - A failure that would make the retry counter equal MAX_RETRIES enters COMMIT instead of ROLLBACK; the packet is dropped.
  - In that cycle txOk_o=0 and extra output txDropped_o=1 (1 cycle).
  - The retry counter is then cleared.
- Disabled:
  - Unlimited retries; every failure rolls back.
  - txDropped_o is absent from the port list.
  - The retry counter saturates at its maximum width instead of wrapping.

Test Plan:
- FIFO holds committed bytes 0x11,0x22,0x33 (isLast on 0x33); pulse txReq_i; txReady_i=1; ACK -> 3 beats, txLast_o on 0x33, one COMMIT cycle with TransDone=1/Success=1, txDone_o=1/txOk_o=1; FIFO then empty.
- Same 3 bytes; hsValid_i=1, hsAck_i=0 -> ROLLBACK cycle with Success=0; second txReq_i resends 0x11,0x22,0x33 unchanged.
- 70 bytes committed, MAX_PKT_LEN=64 -> first packet 64 beats with txLast_o on beat 64; ACK; next request sends 6 bytes with txLast_o on the 6th.
- FIFO empty at txReq_i -> single beat txEmpty_o=1/txLast_o=1, fifoPopData_o never 1; ACK -> COMMIT.
- No handshake after the packet -> ROLLBACK exactly HS_TIMEOUT cycles after WAIT_HS entry; hsValid_i coinciding with the final timeout cycle with hsAck_i=1 -> COMMIT.
- txReady_i toggled 1,0,1 mid-packet, plus rst_i asserted in WAIT_HS -> no byte skipped or duplicated during the stall; after reset all outputs 0 next cycle, state IDLE, no TransDone pulse.
